alu_pipe_unit: RTL

//  Parametrised, pipelined integer execution unit for the OoO core. It is the next generation of the

---
 rtl/alu_pipe_unit_if.sv | 29 ++
 rtl/alu_pipe_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_pipe_unit_if.sv
// Issue-side and CDB-side handshake bundle for alu_pipe_unit.
// The execution unit uses the slave modport; the issue queue / CDB side uses the master modport.
interface alu_pipe_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );
endinterface

// File: rtl/alu_pipe_unit.sv
// Pipelined integer execution unit: the ALU result is computed at accept time and then carried
// through LATENCY registered stages with per-stage valid/ready flow control and flush.
module alu_pipe_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  alu_pipe_unit_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } stage_t;

  if (LATENCY < 1) begin : g_latency_check
    $error("alu_pipe_unit: LATENCY must be at least 1");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("alu_pipe_unit: XLEN must be 32 or 64");
  end

  logic [LATENCY-1:0] stage_valid;
  logic [LATENCY-1:0] stage_load;
  logic [LATENCY-1:0] src_valid;
  stage_t             stage_data [LATENCY];
  stage_t             src_data   [LATENCY];
  stage_t             alu_out;
  logic [SH_W-1:0]    shamt;

  // NOTE: every variable gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    alu_out     = '0;
    alu_out.tag = bus.in_tag;
    shamt       = bus.in_b[SH_W-1:0];
    case (bus.in_op)
      OP_ADD:  alu_out.result = bus.in_a + bus.in_b;
      OP_SUB:  alu_out.result = bus.in_a - bus.in_b;
      OP_SLL:  alu_out.result = bus.in_a << shamt;
      OP_SLT:  alu_out.result = {{(XLEN-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      OP_SLTU: alu_out.result = {{(XLEN-1){1'b0}}, bus.in_a < bus.in_b};
      OP_XOR:  alu_out.result = bus.in_a ^ bus.in_b;
      OP_SRL:  alu_out.result = bus.in_a >> shamt;
      OP_SRA:  alu_out.result = $signed(bus.in_a) >>> shamt;
      OP_OR:   alu_out.result = bus.in_a | bus.in_b;
      OP_AND:  alu_out.result = bus.in_a & bus.in_b;
      default: alu_out.illegal = 1'b1;
    endcase
  end

  // A stage can load iff some stage at or downstream of it is empty, or the CDB drains the output.
  // Written as a scan over the valids rather than a load[i+1] chain to keep the logic acyclic.
  always_comb begin
    stage_load = '0;
    for (int i = 0; i < LATENCY; i++) begin
      stage_load[i] = bus.out_ready;
      for (int j = i; j < LATENCY; j++) begin
        if (!stage_valid[j]) stage_load[i] = 1'b1;
      end
    end
  end

  always_comb begin
    src_valid    = '0;
    src_valid[0] = bus.in_valid;
    src_data[0]  = alu_out;
    for (int i = 1; i < LATENCY; i++) begin
      src_valid[i] = stage_valid[i-1];
      src_data[i]  = stage_data[i-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= '0;
      // NOTE: data regs are reset too, because the output stage must read back as zero after reset.
      for (int i = 0; i < LATENCY; i++) stage_data[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        if (stage_load[i]) begin
          stage_valid[i] <= src_valid[i] && !flush;
          stage_data[i]  <= src_data[i];
        end else if (flush) begin
          stage_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready    = stage_load[0];
  assign bus.out_valid   = stage_valid[LATENCY-1];
  assign bus.out_result  = stage_data[LATENCY-1].result;
  assign bus.out_tag     = stage_data[LATENCY-1].tag;
  assign bus.out_illegal = stage_data[LATENCY-1].illegal;
endmodule
